// File: rtl/mux4_sel_arbiter_if.sv
// Request/grant bundle between the four mux requesters and the select arbiter.
// Requesters drive REQ/LAST/MASK; the arbiter drives the grant and mux selects.
interface mux4_sel_arbiter_if;
    logic [3:0] REQ;
    logic [3:0] LAST;
    logic [3:0] MASK;
    logic [3:0] GNT;
    logic       SL0;
    logic       SL1;
    logic       BUSY;

    modport master (
        output REQ,
        output LAST,
        output MASK,
        input  GNT,
        input  SL0,
        input  SL1,
        input  BUSY
    );

    modport slave (
        input  REQ,
        input  LAST,
        input  MASK,
        output GNT,
        output SL0,
        output SL1,
        output BUSY
    );
endinterface

// File: rtl/mux4_sel_arbiter.sv
// Round-robin owner arbitration for a shared 4:1 select mux, with a burst cap
// so a streaming requester cannot starve the others. Grant and selects are registered.
module mux4_sel_arbiter #(
    parameter int MAXBURST = 4,
    parameter int CW       = 4
) (
    input logic               CK,
    input logic               RST,
    mux4_sel_arbiter_if.slave bus
);
    localparam logic [0:0]    IDLE      = 1'b0;
    localparam logic [0:0]    OWN       = 1'b1;
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW:0]   BURST_LIM = (CW+1)'(MAXBURST);

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [1:0]    sel;
    logic [CW-1:0] cnt;
    logic [3:0]    gnt;
    logic          busy;

    logic [3:0]    elig;
    logic [3:0]    others;
    logic [1:0]    g;
    logic [CW:0]   cnt_plus1;
    logic          beat;
    logic          limit_hit;
    logic          release_own;
    logic [2:0]    idle_pick;
    logic [2:0]    hand_pick;

    // Returns {found, index}: first set bit of v scanning circularly from p.
    function automatic logic [2:0] pick(input logic [3:0] v, input logic [1:0] p);
        logic [2:0] r;
        logic [1:0] k;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (v[k]) r = {1'b1, k};
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    always_comb begin
        elig      = bus.REQ & ~bus.MASK;
        g         = sel;
        others    = elig & ~onehot(g);
        cnt_plus1 = {1'b0, cnt} + (CW+1)'(1);
        beat      = (state == OWN) && bus.REQ[g];
        // The cap only bites when someone else is actually waiting.
        limit_hit = beat && (cnt_plus1 >= BURST_LIM) && (others != 4'b0000);
        release_own = !bus.REQ[g] || bus.MASK[g] || (beat && bus.LAST[g]) || limit_hit;
        idle_pick = pick(elig, ptr);
        hand_pick = pick(others, g + 2'd1);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= '0;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        gnt   <= onehot(idle_pick[1:0]);
                        sel   <= idle_pick[1:0];
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= OWN;
                    end
                end
                default: begin
                    if (release_own) begin
                        ptr <= g + 2'd1;
                        if (hand_pick[2]) begin
                            gnt <= onehot(hand_pick[1:0]);
                            sel <= hand_pick[1:0];
                            cnt <= '0;
                        end else begin
                            // sel is left alone so Z keeps the last owner's input.
                            gnt   <= 4'b0000;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (beat) begin
                        cnt <= sat_inc(cnt);
                    end
                end
            endcase
        end
    end

    assign bus.GNT  = gnt;
    assign bus.SL0  = sel[0];
    assign bus.SL1  = sel[1];
    assign bus.BUSY = busy;
endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Directed bench for mux4_sel_arbiter (MAXBURST=4, CW=4): vector table plus
// hand sequences for burst cap, lone requester saturation and LAST+cap overlap.
module tb_mux4_sel_arbiter;
    logic CK;
    logic RST;
    int   nchecks;
    int   nerr;

    mux4_sel_arbiter_if bus ();

    mux4_sel_arbiter #(.MAXBURST(4), .CW(4)) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] mask;
        logic [3:0] gnt;
        logic [1:0] sl;
        logic       busy;
    } vec_t;

    vec_t tbl[22];

    task automatic step(input logic rst, input logic [3:0] req,
                        input logic [3:0] last, input logic [3:0] mask);
        RST      = rst;
        bus.REQ  = req;
        bus.LAST = last;
        bus.MASK = mask;
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] eg,
                         input logic [1:0] es, input logic eb);
        logic [1:0] sl;
        sl = {bus.SL1, bus.SL0};
        nchecks++;
        if (bus.GNT !== eg || sl !== es || bus.BUSY !== eb) begin
            nerr++;
            $display("FAIL %s: got gnt=%b sl=%b busy=%b, expected gnt=%b sl=%b busy=%b",
                     nm, bus.GNT, sl, bus.BUSY, eg, es, eb);
        end
        nchecks++;
        if ((^{bus.GNT, sl, bus.BUSY}) === 1'bx || $countones(bus.GNT) > 1 ||
            ((bus.GNT != 4'b0000) != bus.BUSY) ||
            (bus.BUSY && bus.GNT != (4'b0001 << sl))) begin
            nerr++;
            $display("FAIL %s_invariant: got gnt=%b sl=%b busy=%b, expected clean one-hot grant matching sl/busy",
                     nm, bus.GNT, sl, bus.BUSY);
        end
    endtask

    initial begin
        nchecks  = 0;
        nerr     = 0;
        RST      = 1'b1;
        bus.REQ  = 4'b0000;
        bus.LAST = 4'b0000;
        bus.MASK = 4'b0000;

        //          rst  req      last     mask     gnt      sl     busy
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
        tbl[5]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
        tbl[6]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
        tbl[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1};
        tbl[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1};
        tbl[9]  = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[12] = '{1'b0, 4'b0110, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[13] = '{1'b0, 4'b0110, 4'b0000, 4'b0010, 4'b0100, 2'd2, 1'b1};
        tbl[14] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[15] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0};
        tbl[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0};
        tbl[17] = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1};
        tbl[18] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[20] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1};
        tbl[21] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0};

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].mask);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sl, tbl[i].busy);
        end

        // Burst cap: requester 0 streams, requester 3 joins on beat 2.
        step(1'b0, 4'b0001, 4'b0000, 4'b0000);
        check("burst_grant", 4'b0001, 2'd0, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            step(1'b0, (b >= 2) ? 4'b1001 : 4'b0001, 4'b0000, 4'b0000);
            if (b < 4) check($sformatf("burst_beat%0d", b), 4'b0001, 2'd0, 1'b1);
            else       check("burst_handoff", 4'b1000, 2'd3, 1'b1);
        end
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
        check("burst_idle", 4'b0000, 2'd3, 1'b0);

        // Lone requester keeps the grant while its count saturates.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        check("lone_reset", 4'b0000, 2'd0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0010, 4'b0000, 4'b0000);
            check($sformatf("lone_cyc%0d", c), 4'b0010, 2'd1, 1'b1);
        end
        step(1'b0, 4'b0011, 4'b0000, 4'b0000);
        check("lone_sat_release", 4'b0001, 2'd0, 1'b1);

        // LAST coinciding with the burst cap: one release, handoff to requester 1.
        for (int b = 1; b <= 4; b++) begin
            step(1'b0, 4'b0011, (b == 4) ? 4'b0001 : 4'b0000, 4'b0000);
            if (b < 4) check($sformatf("lastcap_beat%0d", b), 4'b0001, 2'd0, 1'b1);
            else       check("lastcap_handoff", 4'b0010, 2'd1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/mux4_sel_arbiter.md
Name: mux4_sel_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 select mux (A0..A3 -> Z, selects SL0/SL1) between four requesters.
- Decides which requester owns the mux, drives the registered SL1:SL0 select lines and a one-hot grant.
- Enforces a maximum burst length so no requester starves the others.
- Sits beside the mux cell in the datapath; requesters put data on A0..A3 and read the result on Z.

Parameters:
- MAXBURST, 4, maximum beats one owner may take while another enabled request is pending. Legal range 1..15.
- CW, 4, burst counter width. Must satisfy 2**CW > MAXBURST.

Ports:
- CK  input  1  clock, all state on rising edge
- RST  input  1  synchronous reset, active-high
- REQ  input  4  request per requester; REQ[i] is tied to mux input Ai
- LAST  input  4  LAST[i] marks requester i's final beat; sampled only on a beat
- MASK  input  4  MASK[i]=1 disables requester i (configuration, may change any cycle)
- GNT  output  4  one-hot grant, registered; all zero when idle
- SL0  output  1  select bit 0 = grantee index bit 0, registered
- SL1  output  1  select bit 1 = grantee index bit 1, registered
- BUSY  output  1  high while a grant is held, registered

Behaviour:
- Reset, taken on CK edge with RST=1, overrides everything including a grant in progress. Values after reset:
  - GNT=0000, SL0=0, SL1=0, BUSY=0.
  - State IDLE, pointer PTR=0, burst count CNT=0.
- Definitions:
  - Eligible vector: E = REQ & ~MASK.
  - Beat: a cycle with GNT[g]=1 and REQ[g]=1, where g is the current grantee.
- State IDLE:
  - E==0: stay in IDLE.
  - E!=0: pick the first set bit of E scanning circularly from PTR (PTR, PTR+1, ... mod 4). Call it w.
  - Next edge: GNT=onehot(w), {SL1,SL0}=w, BUSY=1, CNT=0, go to OWN.
  - Latency from REQ rising to GNT is one cycle.
- State OWN, grantee g:
  - Each beat increments CNT, saturating at 2**CW-1.
  - Release conditions, any of:
    - (a) REQ[g]=0
    - (b) MASK[g]=1
    - (c) beat with LAST[g]=1
    - (d) beat where CNT+1 >= MAXBURST and (E with bit g cleared) != 0
  - On release, PTR <= (g+1) mod 4.
  - Same-cycle re-arbitration at release: scan (E with bit g cleared) from the new PTR.
    - If a winner w exists: next edge GNT=onehot(w), SL=w, CNT=0, stay in OWN. No idle gap on handoff.
    - If none: go to IDLE, GNT=0000, BUSY=0.
  - Handoff to itself is not possible at release. If g still requests, it is served later in round-robin order.
  - With no other eligible request, condition (d) never fires; g keeps the grant indefinitely with CNT saturating.
- Select hold:
  - In IDLE, SL1/SL0 hold the last grantee index (no glitch on Z for a stale requester).
  - After reset they are 00.
- Invariants:
  - GNT is zero or one-hot.
  - GNT!=0 iff BUSY=1.
  - When BUSY=1, {SL1,SL0} equals the index of the set GNT bit.
- Simultaneous events:
  - LAST and burst limit in the same beat count as a single release.
  - A MASK change and a REQ change in the same cycle are both evaluated through E in that cycle.
- X handling: none. Inputs are assumed driven after reset; the bench checks for no X on outputs after the first reset edge.

Test Plan:
- Reset mid-burst: grant held on requester 2, assert RST for one cycle -> next edge GNT=0000, SL=00, BUSY=0; REQ=0100 still high -> GNT=0100 one cycle after RST drops.
- Round robin: REQ=1111 held, LAST pulsed on every beat -> grant sequence 0001,0010,0100,1000,0001, one beat each, no idle cycles, SL sequence 00,01,10,11,00.
- Burst limit, MAXBURST=4: requester 0 holds REQ without LAST; REQ[3] rises at beat 2 -> GNT[0] for exactly 4 beats, then GNT=1000 and SL=11 the next cycle.
- Lone requester: REQ=0010 with no LAST for 20 cycles -> GNT=0010 continuously, BUSY=1, CNT saturates, no release.
- MASK: grant on requester 1, set MASK=0010 -> next edge grant moves to the next eligible requester (REQ=0110 -> GNT=0100); with REQ=0010 only -> IDLE, GNT=0000, SL stays 01.
- Drop release: requester 3 granted, REQ[3] falls, REQ=0001 -> next edge GNT=0001, SL=00, PTR=0.
